// File: rtl/sram_fifo_pkg.sv
// Shared defaults and width helpers for the SRAM-backed latency-absorbing FIFO.
package sram_fifo_pkg;

    localparam int DEF_WIDTH   = 8;
    localparam int DEF_DEPTH   = 8;
    localparam int DEF_LATENCY = 5;

    // Occupancy must cover every SRAM entry plus every output-buffer slot, and zero.
    function automatic int cnt_width(input int depth, input int out_depth);
        return $clog2(depth + out_depth + 1);
    endfunction

endpackage

// File: rtl/sram_fifo_obuf.sv
// Small register FIFO that catches SRAM read returns and presents the head entry.
module sram_fifo_obuf
    import sram_fifo_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_LATENCY + 1,
    parameter int CNT_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    output logic [CNT_W-1:0] cnt_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_cnt;

    // DEPTH need not be a power of two, so pointers wrap explicitly.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        if (ptr == PTR_W'(DEPTH - 1)) begin
            return {PTR_W{1'b0}};
        end else begin
            return ptr + PTR_W'(1);
        end
    endfunction

    // Storage, pointers and occupancy.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {WIDTH{1'b0}};
            end
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_cnt    <= {CNT_W{1'b0}};
        end else begin
            if (push_i) begin
                r_mem[r_wr_ptr] <= data_i;
            end
            r_wr_ptr <= push_i ? ptr_inc(r_wr_ptr) : r_wr_ptr;
            r_rd_ptr <= pop_i ? ptr_inc(r_rd_ptr) : r_rd_ptr;
            r_cnt    <= r_cnt + CNT_W'(push_i) - CNT_W'(pop_i);
        end
    end

    assign valid_o = (r_cnt != {CNT_W{1'b0}});
    assign data_o  = r_mem[r_rd_ptr];
    assign cnt_o   = r_cnt;

endmodule

// File: rtl/sram_latency_fifo_ctrl.sv
// Streaming FIFO controller over a fixed-latency dual-port SRAM; reads are issued
// only when the output buffer is guaranteed room for every in-flight return.
module sram_latency_fifo_ctrl
    import sram_fifo_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int LATENCY   = DEF_LATENCY,
    parameter int OUT_DEPTH = LATENCY + 1,
    parameter int ADDR_W    = $clog2(DEPTH),
    parameter int CNT_W     = cnt_width(DEPTH, OUT_DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              push_valid_i,
    input  logic [WIDTH-1:0]  push_data_i,
    output logic              push_ready_o,
    output logic              pop_valid_o,
    output logic [WIDTH-1:0]  pop_data_o,
    input  logic              pop_ready_i,
    output logic              sram_wen_o,
    output logic [ADDR_W-1:0] sram_waddr_o,
    output logic [WIDTH-1:0]  sram_wdata_o,
    output logic              sram_ren_o,
    output logic [ADDR_W-1:0] sram_raddr_o,
    input  logic [WIDTH-1:0]  sram_rdata_i,
    input  logic              sram_rvld_i,
    output logic [CNT_W-1:0]  count_o
);

    logic [ADDR_W-1:0] r_wptr;
    logic [ADDR_W-1:0] r_rptr;
    logic [CNT_W-1:0]  r_sram_cnt;
    logic [CNT_W-1:0]  r_inflight;
    logic [CNT_W-1:0]  r_count;
    logic              r_push_ready;

    logic              w_push_fire;
    logic              w_pop_fire;
    logic              w_pop_valid;
    logic              w_rvld;
    logic              w_issue;
    logic [CNT_W-1:0]  w_obuf_cnt;
    logic [CNT_W-1:0]  w_sram_cnt_nxt;
    logic [CNT_W-1:0]  w_inflight_nxt;
    logic [CNT_W-1:0]  w_obuf_cnt_nxt;

    // Handshakes, read credit and next-state counter values.
    always_comb begin
        w_push_fire    = push_valid_i & r_push_ready;
        w_pop_fire     = w_pop_valid & pop_ready_i;
        // Returns with nothing outstanding (e.g. reads launched before a reset) are dropped.
        w_rvld         = sram_rvld_i & (r_inflight != {CNT_W{1'b0}});
        // Credit compare is arranged as a sum on both sides so it cannot underflow.
        w_issue        = (r_sram_cnt != {CNT_W{1'b0}}) &&
                         ((r_inflight + w_obuf_cnt) < (CNT_W'(OUT_DEPTH) + CNT_W'(w_pop_fire)));
        w_sram_cnt_nxt = r_sram_cnt + CNT_W'(w_push_fire) - CNT_W'(w_issue);
        w_inflight_nxt = r_inflight + CNT_W'(w_issue) - CNT_W'(w_rvld);
        w_obuf_cnt_nxt = w_obuf_cnt + CNT_W'(w_rvld) - CNT_W'(w_pop_fire);
    end

    // Pointers, SRAM-side counters and the registered status outputs.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_wptr       <= {ADDR_W{1'b0}};
            r_rptr       <= {ADDR_W{1'b0}};
            r_sram_cnt   <= {CNT_W{1'b0}};
            r_inflight   <= {CNT_W{1'b0}};
            r_count      <= {CNT_W{1'b0}};
            r_push_ready <= 1'b1;
        end else begin
            r_wptr       <= w_push_fire ? (r_wptr + ADDR_W'(1)) : r_wptr;
            r_rptr       <= w_issue ? (r_rptr + ADDR_W'(1)) : r_rptr;
            r_sram_cnt   <= w_sram_cnt_nxt;
            r_inflight   <= w_inflight_nxt;
            r_count      <= w_sram_cnt_nxt + w_inflight_nxt + w_obuf_cnt_nxt;
            r_push_ready <= (w_sram_cnt_nxt < CNT_W'(DEPTH));
        end
    end

    sram_fifo_obuf #(
        .WIDTH (WIDTH),
        .DEPTH (OUT_DEPTH),
        .CNT_W (CNT_W)
    ) u_obuf (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (w_rvld),
        .data_i  (sram_rdata_i),
        .pop_i   (w_pop_fire),
        .valid_o (w_pop_valid),
        .data_o  (pop_data_o),
        .cnt_o   (w_obuf_cnt)
    );

    assign push_ready_o = r_push_ready;
    assign pop_valid_o  = w_pop_valid;
    assign sram_wen_o   = w_push_fire;
    assign sram_waddr_o = r_wptr;
    assign sram_wdata_o = push_data_i;
    assign sram_ren_o   = w_issue;
    assign sram_raddr_o = r_rptr;
    assign count_o      = r_count;

endmodule

// File: doc/sram_latency_fifo_ctrl.md
# sram_latency_fifo_ctrl

Controller that turns a fixed-latency dual-port SRAM into a valid/ready streaming FIFO. It owns the write/read pointers and the occupancy count, and issues SRAM reads only when the in-flight results are guaranteed a slot. It also absorbs the SRAM's read latency in a small output buffer so the pop side sees zero-bubble throughput. The SRAM itself sits outside this block, wired to the `sram_*` ports.

## Interface
- `WIDTH`, 8: data width.
- `DEPTH`, 8: SRAM entries; power of two, ≥2.
- `LATENCY`, 5: SRAM read latency in cycles from `sram_ren_o` to `sram_rvld_i`; ≥1.
- `OUT_DEPTH`, LATENCY+1: output buffer entries.
- `ADDR_W`, $clog2(DEPTH): SRAM address width.
- `CNT_W`, $clog2(DEPTH+OUT_DEPTH+1): occupancy width.

Ports:
- `clk_i` in 1: clock.
- `rst_i` in 1: reset, asynchronous, active-low.
- `push_valid_i` in 1: write request.
- `push_data_i` in WIDTH: write data.
- `push_ready_o` out 1: write accepted when valid && ready.
- `pop_valid_o` out 1: head data available.
- `pop_data_o` out WIDTH: head data.
- `pop_ready_i` in 1: consumer takes head when valid && ready.
- `sram_wen_o` out 1: SRAM write enable.
- `sram_waddr_o` out ADDR_W: SRAM write address.
- `sram_wdata_o` out WIDTH: SRAM write data.
- `sram_ren_o` out 1: SRAM read enable.
- `sram_raddr_o` out ADDR_W: SRAM read address.
- `sram_rdata_i` in WIDTH: SRAM read data, qualified by `sram_rvld_i`.
- `sram_rvld_i` in 1: SRAM read data valid.
- `count_o` out CNT_W: total entries held (SRAM + in flight + output buffer).

## Operation
- **Push:**
  - `push_ready_o` = (`sram_cnt` < DEPTH), a registered compare.
  - On a handshake, `sram_wen_o`=1, `sram_waddr_o`=`wptr`, `sram_wdata_o`=`push_data_i` in the same cycle (combinational pass-through).
  - `wptr` increments and wraps at DEPTH.
- **Read issue:**
  - Issue when `sram_cnt` > 0 && (`inflight` + `obuf_cnt` − pop_fire) < OUT_DEPTH.
  - On issue, `sram_ren_o`=1 and `sram_raddr_o`=`rptr`; `rptr` wraps.
  - `sram_cnt` and `inflight` are registered. An entry written in cycle t is first readable at t+1, so there is never a read-during-write hazard on the same address.
- **Counters:**
  - `sram_cnt` += push_fire − issue.
  - `inflight` += issue − `sram_rvld_i`.
  - `obuf_cnt` += `sram_rvld_i` − pop_fire.
  - Simultaneous increment and decrement leaves the counter unchanged.
- **Output buffer:**
  - Register FIFO of OUT_DEPTH entries written on `sram_rvld_i`.
  - `pop_valid_o` = `obuf_cnt` != 0; `pop_data_o` = head entry, registered.
  - The credit rule guarantees it never overflows.
- **`count_o`** = `sram_cnt` + `inflight` + `obuf_cnt`, registered.
- **Boundaries:**
  - Full: push with `push_ready_o`=0 is ignored and no state changes.
  - Empty: `pop_ready_i` with `pop_valid_o`=0 is ignored.
  - Stray `sram_rvld_i` while `inflight`==0 is dropped; no counter underflow.
- **Reset:**
  - Asynchronous; all pointers and counters go to 0.
  - Reset values: `push_ready_o`=1, `pop_valid_o`=0, `pop_data_o`=0, `sram_wen_o`=0, `sram_ren_o`=0, addresses 0, `count_o`=0.
  - Reset mid-operation discards all contents. Data returning from reads in flight at reset falls under the stray-`sram_rvld_i` rule.
  - The SRAM's valid pipeline must be reset in the same window.

## Timing
- Push at cycle t → read issue at t+1 → `sram_rvld_i` at t+1+LATENCY → `pop_valid_o` at t+2+LATENCY. For LATENCY=5, first-word latency is 7 cycles.
- Throughput is 1 push and 1 pop per cycle sustained. OUT_DEPTH ≥ LATENCY+1 is required for no pop-side bubbles with `pop_ready_i` held high.
- With `pop_ready_i`=0, at most OUT_DEPTH reads are outstanding plus buffered, after which issue stalls.
- Capacity is DEPTH+OUT_DEPTH entries; `push_ready_o` depends only on `sram_cnt`.

## Structure
- Package `sram_fifo_pkg`: default WIDTH/DEPTH/LATENCY localparams and a helper function for CNT_W.
- Sub-module `sram_fifo_obuf`: register FIFO with OUT_DEPTH entries, push on `sram_rvld_i`, pop on handshake, exposing `cnt`.
- Top contains the pointers, `sram_cnt`, the `inflight` counter, and the issue logic.

## Test plan
- **Single word:** push 0xA5 at cycle 0 with `pop_ready_i`=1 → `sram_ren_o` at cycle 1, `pop_valid_o`=1 with `pop_data_o`=0xA5 at cycle 7, `count_o` back to 0 at cycle 8.
- **Streaming:** push 0..31 back-to-back with `pop_ready_i`=1 → pops 0..31 in order, one per cycle from cycle 7, with no bubbles.
- **Fill:** `pop_ready_i`=0, push 20 words → 6 reach the output buffer, `push_ready_o` drops after the 14th accepted, `count_o`=14.
  - Then `pop_ready_i`=1 → `push_ready_o` re-rises and all 14 words drain in order.
- **Wrap plus simultaneous push/pop:** 100 random pushes and pops at DEPTH=8 → pointers wrap repeatedly, order is preserved, and `count_o` matches the scoreboard every cycle.
- **Reset mid-operation:** assert `rst_i` low with 3 reads in flight → all outputs take their reset values immediately. Late `sram_rvld_i` pulses are dropped, `pop_valid_o` stays 0, and `count_o` stays 0.
